// File: rtl/nfc_ecc_ctrl_pkg.sv
// nfc_ecc_ctrl_pkg: shared state encoding, default widths and error-list marker constants.
package nfc_ecc_ctrl_pkg;
    localparam int DAT_WID_DEF  = 16;
    localparam int ECC_AWID_DEF = 12;
    localparam int BUF_AWID_DEF = 12;
    // Markers are truncated to ECC_AWID at the point of use.
    localparam logic [31:0] ECC_END   = 32'h0000_0000;
    localparam logic [31:0] ECC_UNCOR = 32'hFFFF_FFFF;
    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, FIFO_RD, FIFO_CAP, CHK, BUF_RD, BUF_WR, DONE
    } state_t;
endpackage

// File: rtl/nfc_ecc_ctrl_if.sv
// nfc_ecc_ctrl_if: ECC FIFO read port plus page-buffer arbiter port.
interface nfc_ecc_ctrl_if
    import nfc_ecc_ctrl_pkg::*;
#(
    parameter int DAT_WID  = DAT_WID_DEF,
    parameter int ECC_AWID = ECC_AWID_DEF,
    parameter int BUF_AWID = BUF_AWID_DEF
);
    logic                ecc_enc_rdy;
    logic                ecc_dec_rdy;
    logic                mem_if_rd;
    logic [DAT_WID-1:0]  mem_enc_dat;
    logic [ECC_AWID-1:0] mem_dec_addr;
    logic                buf_req;
    logic                buf_we;
    logic [BUF_AWID-1:0] buf_addr;
    logic [DAT_WID-1:0]  buf_wdat;
    logic [DAT_WID-1:0]  buf_rdat;
    logic                buf_ack;
    modport master (
        output mem_if_rd, buf_req, buf_we, buf_addr, buf_wdat,
        input  ecc_enc_rdy, ecc_dec_rdy, mem_enc_dat, mem_dec_addr, buf_rdat, buf_ack
    );
    modport slave (
        input  mem_if_rd, buf_req, buf_we, buf_addr, buf_wdat,
        output ecc_enc_rdy, ecc_dec_rdy, mem_enc_dat, mem_dec_addr, buf_rdat, buf_ack
    );
endinterface

// File: rtl/nfc_ecc_ctrl_bitflip.sv
// nfc_ecc_bitflip: inverts one selected bit of a buffer word.
module nfc_ecc_bitflip #(
    parameter int DAT_WID = 16
) (
    input  logic [DAT_WID-1:0]         word,
    input  logic [$clog2(DAT_WID)-1:0] sel,
    output logic [DAT_WID-1:0]         fixed
);
    assign fixed = word ^ (DAT_WID'(1) << sel);
endmodule

// File: rtl/nfc_ecc_ctrl.sv
// nfc_ecc_ctrl: per-sector ECC FIFO sequencer -- parity write-out (encode) and bit correction (decode).
// Define NFC_ECC_ERRCNT_EN to enable the saturating cumulative error counter err_total.
module nfc_ecc_ctrl
    import nfc_ecc_ctrl_pkg::*;
#(
    parameter int          DAT_WID    = DAT_WID_DEF,
    parameter int          ECC_AWID   = ECC_AWID_DEF,
    parameter int          BUF_AWID   = BUF_AWID_DEF,
    parameter int unsigned SECT_WORDS = 256,
    parameter int unsigned PAR_WORDS  = 7,
    parameter int unsigned MAX_ERR    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                dir,
    input  logic [BUF_AWID-1:0] sect_base,
    input  logic [BUF_AWID-1:0] spare_base,
    input  logic                abort,
    nfc_ecc_ctrl_if.master      bus,
    output logic                busy,
    output logic                done,
    output logic [4:0]          err_num,
    output logic                uncor,
    input  logic                err_clr,
    output logic [15:0]         err_total
);
    localparam int LW = $clog2(DAT_WID);
    state_t              state;
    logic                is_enc;
    logic [BUF_AWID-1:0] sbase, pbase;
    logic [4:0]          idx, idx_n;
    logic                last;
    logic [ECC_AWID-1:0] ent, loc, off;
    logic [DAT_WID-1:0]  fixed;
    assign idx_n = idx + 5'd1;
    assign last  = idx_n == (is_enc ? 5'(PAR_WORDS) : 5'(MAX_ERR));
    assign loc   = ent - ECC_AWID'(1);
    assign off   = loc >> LW;
    nfc_ecc_bitflip #(.DAT_WID(DAT_WID)) u_flip (
        .word(bus.buf_rdat), .sel(loc[LW-1:0]), .fixed(fixed)
    );
    // Decode enters BUF_WR with buf_req low, giving the arbiter one idle cycle between read and write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            is_enc        <= 1'b0;
            sbase         <= '0;
            pbase         <= '0;
            idx           <= '0;
            ent           <= '0;
            bus.mem_if_rd <= 1'b0;
            bus.buf_req   <= 1'b0;
            bus.buf_we    <= 1'b0;
            bus.buf_addr  <= '0;
            bus.buf_wdat  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_num       <= '0;
            uncor         <= 1'b0;
        end else if (abort) begin
            state         <= IDLE;
            bus.mem_if_rd <= 1'b0;
            bus.buf_req   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= WAIT_RDY;
                    busy    <= 1'b1;
                    is_enc  <= dir;
                    sbase   <= sect_base;
                    pbase   <= spare_base;
                    idx     <= '0;
                    err_num <= '0;
                    uncor   <= 1'b0;
                end
                WAIT_RDY: if (is_enc ? bus.ecc_enc_rdy : bus.ecc_dec_rdy) begin
                    state         <= FIFO_RD;
                    bus.mem_if_rd <= 1'b1;
                end
                FIFO_RD: begin
                    state         <= FIFO_CAP;
                    bus.mem_if_rd <= 1'b0;
                end
                FIFO_CAP: if (is_enc) begin
                    state        <= BUF_WR;
                    bus.buf_req  <= 1'b1;
                    bus.buf_we   <= 1'b1;
                    bus.buf_addr <= pbase + BUF_AWID'(idx);
                    bus.buf_wdat <= bus.mem_enc_dat;
                end else begin
                    state <= CHK;
                    ent   <= bus.mem_dec_addr;
                end
                CHK: if (ent == ECC_AWID'(ECC_END)) begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end else if (ent == ECC_AWID'(ECC_UNCOR)) begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    uncor <= 1'b1;
                end else if (32'(off) >= SECT_WORDS) begin
                    uncor         <= 1'b1;
                    idx           <= idx_n;
                    state         <= last ? DONE : FIFO_RD;
                    bus.mem_if_rd <= !last;
                    done          <= last;
                    busy          <= !last;
                end else begin
                    state        <= BUF_RD;
                    bus.buf_req  <= 1'b1;
                    bus.buf_we   <= 1'b0;
                    bus.buf_addr <= sbase + BUF_AWID'(off);
                end
                BUF_RD: if (bus.buf_ack) begin
                    state        <= BUF_WR;
                    bus.buf_req  <= 1'b0;
                    bus.buf_we   <= 1'b1;
                    bus.buf_wdat <= fixed;
                end
                BUF_WR: if (!bus.buf_req) begin
                    bus.buf_req <= 1'b1;
                end else if (bus.buf_ack) begin
                    bus.buf_req   <= 1'b0;
                    idx           <= idx_n;
                    err_num       <= is_enc ? err_num : err_num + 5'd1;
                    state         <= last ? DONE : FIFO_RD;
                    bus.mem_if_rd <= !last;
                    done          <= last;
                    busy          <= !last;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef NFC_ECC_ERRCNT_EN
    logic [16:0] sum;
    assign sum = {1'b0, err_total} + 17'(err_num);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_total <= '0;
        else if (err_clr)
            err_total <= '0;
        else if (state == DONE && !is_enc)
            err_total <= sum[16] ? 16'hFFFF : sum[15:0];
    end
`else
    logic unused_clr;
    assign unused_clr = err_clr;
    assign err_total  = '0;
`endif
endmodule
